mp_ingress_buf: RTL and testbench

Parametrised per-port ingress packet buffer for the multi-port cache. It accepts the sop/eop/vld/data write stream on each input port, checks packet framing, and stores each beat with its sideband in a per-port FIFO. It drives per-port `ready`, `full` and the global `almost_full` backpressure, and replays packets on a per-port read stream. A `MODE` parameter selects cut-through or store-and-forward release.

---
 rtl/mp_pkg.sv | 22 ++
 rtl/mp_port_fifo.sv | 97 +++++++++
 rtl/mp_ingress_buf.sv | 58 +++++
 tb/tb_mp_ingress_buf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: shared constants, framing states and stored-entry sideband for the ingress buffer.
package mp_pkg;

    localparam int PORT_NUM   = 16;
    localparam int DATA_WIDTH = 64;

    localparam int MODE_CT = 0;
    localparam int MODE_SF = 1;

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_e;

    // Sideband kept next to every stored beat; data lives in a parallel array.
    typedef struct packed {
        logic err;
        logic sop;
        logic eop;
    } entry_tag_t;

endpackage

// File: rtl/mp_port_fifo.sv
// mp_port_fifo: one port's framing checker, FWFT FIFO, packet counter and
// store-and-forward deadlock bypass.
module mp_port_fifo
    import mp_pkg::*;
#(
    parameter int DW       = 64,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int MODE     = MODE_CT
) (
    input  logic          clk,
    input  logic          rst_n_in,
    input  logic          wr_sop,
    input  logic          wr_eop,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_data,
    output logic          ready,
    input  logic          rd_rdy,
    output logic          rd_sop,
    output logic          rd_eop,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    output logic          rd_err,
    output logic          full,
    output logic          almost_full,
    output logic          frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];

    logic [DW-1:0]  data_mem [DEPTH];
    entry_tag_t     tag_mem  [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d, pkt_cnt_q, pkt_cnt_d;
    frame_state_e   state_q, state_d;
    logic           bypass_q, bypass_d, frame_err_q, frame_err_d;
    logic           acc, push, pop, eligible;
    entry_tag_t     wr_tag, head;

    assign ready       = cnt_q < DEPTH_C;
    assign full        = cnt_q == DEPTH_C;
    assign almost_full = cnt_q >= AF_C;
    assign frame_err   = frame_err_q;

    always_comb begin
        acc         = wr_vld && ready;
        push        = acc && (wr_sop || state_q == IN_PKT);
        frame_err_d = acc && (state_q == IDLE ? !wr_sop : wr_sop);
        state_d     = push ? (wr_eop ? IDLE : IN_PKT) : state_q;
        wr_tag      = '{err: state_q == IN_PKT && wr_sop, sop: wr_sop, eop: wr_eop};
        head        = tag_mem[rd_ptr_q];
        eligible    = MODE == MODE_CT || pkt_cnt_q != '0 || bypass_q;
        rd_vld      = eligible && cnt_q != '0;
        pop         = rd_vld && rd_rdy;
        rd_data     = data_mem[rd_ptr_q];
        rd_sop      = rd_vld && head.sop;
        rd_eop      = rd_vld && head.eop;
        rd_err      = rd_vld && head.err;
        wr_ptr_d    = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        cnt_d       = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        pkt_cnt_d   = pkt_cnt_q + {{AW{1'b0}}, push && wr_eop} - {{AW{1'b0}}, pop && head.eop};
        // A full FIFO with no complete packet can never become eligible; drain it as cut-through.
        bypass_d    = MODE == MODE_SF &&
                      ((pop && head.eop) ? 1'b0 : (bypass_q || (full && pkt_cnt_q == '0)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= wr_data;
            tag_mem[wr_ptr_q]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            pkt_cnt_q   <= '0;
            state_q     <= IDLE;
            bypass_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            state_q     <= state_d;
            bypass_q    <= bypass_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: rtl/mp_ingress_buf.sv
// mp_ingress_buf: per-port ingress packet buffers with framing checks and
// cut-through or store-and-forward release.
module mp_ingress_buf #(
    parameter int PORT_NUM   = mp_pkg::PORT_NUM,
    parameter int DATA_WIDTH = mp_pkg::DATA_WIDTH,
    parameter int DEPTH      = 32,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int MODE       = mp_pkg::MODE_CT
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic [PORT_NUM-1:0]   wr_sop,
    input  logic [PORT_NUM-1:0]   wr_eop,
    input  logic [PORT_NUM-1:0]   wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data [PORT_NUM],
    output logic [PORT_NUM-1:0]   ready,
    input  logic [PORT_NUM-1:0]   rd_rdy,
    output logic [PORT_NUM-1:0]   rd_sop,
    output logic [PORT_NUM-1:0]   rd_eop,
    output logic [PORT_NUM-1:0]   rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data [PORT_NUM],
    output logic [PORT_NUM-1:0]   rd_err,
    output logic [PORT_NUM-1:0]   full,
    output logic                  almost_full,
    output logic [PORT_NUM-1:0]   frame_err
);

    logic [PORT_NUM-1:0] port_af;

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        mp_port_fifo #(
            .DW       (DATA_WIDTH),
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL),
            .MODE     (MODE)
        ) u_fifo (
            .clk         (clk),
            .rst_n_in    (rst_n_in),
            .wr_sop      (wr_sop[p]),
            .wr_eop      (wr_eop[p]),
            .wr_vld      (wr_vld[p]),
            .wr_data     (wr_data[p]),
            .ready       (ready[p]),
            .rd_rdy      (rd_rdy[p]),
            .rd_sop      (rd_sop[p]),
            .rd_eop      (rd_eop[p]),
            .rd_vld      (rd_vld[p]),
            .rd_data     (rd_data[p]),
            .rd_err      (rd_err[p]),
            .full        (full[p]),
            .almost_full (port_af[p]),
            .frame_err   (frame_err[p])
        );
    end

    assign almost_full = |port_af;

endmodule

// File: tb/tb_mp_ingress_buf.sv
// tb_mp_ingress_buf: directed checks of a cut-through and a store-and-forward
// instance driven side by side.
module tb_mp_ingress_buf;

    localparam int P = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [P-1:0] a_sop, a_eop, a_vld, a_rdy, a_ready, a_rsop, a_reop, a_rvld, a_rerr, a_full, a_ferr;
    logic [P-1:0] b_sop, b_eop, b_vld, b_rdy, b_ready, b_rsop, b_reop, b_rvld, b_rerr, b_full, b_ferr;
    logic         a_af, b_af;
    logic [W-1:0] a_wd [P];
    logic [W-1:0] a_rd [P];
    logic [W-1:0] b_wd [P];
    logic [W-1:0] b_rd [P];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_ingress_buf #(.PORT_NUM(P), .DATA_WIDTH(W), .DEPTH(16), .AF_LEVEL(12), .MODE(0)) u_ct (
        .clk(clk), .rst_n_in(rst_n), .wr_sop(a_sop), .wr_eop(a_eop), .wr_vld(a_vld), .wr_data(a_wd),
        .ready(a_ready), .rd_rdy(a_rdy), .rd_sop(a_rsop), .rd_eop(a_reop), .rd_vld(a_rvld),
        .rd_data(a_rd), .rd_err(a_rerr), .full(a_full), .almost_full(a_af), .frame_err(a_ferr)
    );

    mp_ingress_buf #(.PORT_NUM(P), .DATA_WIDTH(W), .DEPTH(16), .AF_LEVEL(12), .MODE(1)) u_sf (
        .clk(clk), .rst_n_in(rst_n), .wr_sop(b_sop), .wr_eop(b_eop), .wr_vld(b_vld), .wr_data(b_wd),
        .ready(b_ready), .rd_rdy(b_rdy), .rd_sop(b_rsop), .rd_eop(b_reop), .rd_vld(b_rvld),
        .rd_data(b_rd), .rd_err(b_rerr), .full(b_full), .almost_full(b_af), .frame_err(b_ferr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] got [20];
        int n, j;
        a_sop = '0; a_eop = '0; a_vld = '0; a_rdy = '0;
        b_sop = '0; b_eop = '0; b_vld = '0; b_rdy = '0;
        for (int i = 0; i < P; i++) begin
            a_wd[i] = '0;
            b_wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", {28'b0, a_ready}, 32'hF);
        chk("rst_full", {28'b0, a_full | b_full}, 0);
        chk("rst_af", {31'b0, a_af | b_af}, 0);
        chk("rst_rvld", {28'b0, a_rvld | b_rvld}, 0);
        chk("rst_ferr", {28'b0, a_ferr | b_ferr}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {24'b0, b_ready, a_ready}, 32'hFF);
        chk("idle_full", {28'b0, a_full | b_full}, 0);
        chk("idle_rvld", {28'b0, a_rvld | b_rvld}, 0);

        // cut-through 3-beat packet on port 2
        a_rdy[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_vld[2] = 1'b1; a_sop[2] = (k == 0); a_eop[2] = (k == 2); a_wd[2] = 32'hA0 + k;
            @(negedge clk);
            chk("ct_vld", {31'b0, a_rvld[2]}, 1);
            chk("ct_data", a_rd[2], 32'hA0 + k);
            chk("ct_sop_eop", {30'b0, a_rsop[2], a_reop[2]}, {30'b0, k == 0, k == 2});
            chk("ct_err", {31'b0, a_rerr[2]}, 0);
        end
        a_vld[2] = 1'b0;
        @(negedge clk);
        chk("ct_drained", {31'b0, a_rvld[2]}, 0);
        a_rdy[2] = 1'b0;

        // fill port 0 with no reader
        for (int i = 0; i < 16; i++) begin
            a_vld[0] = 1'b1; a_sop[0] = (i == 0); a_eop[0] = 1'b0; a_wd[0] = 32'h100 + i;
            @(negedge clk);
            if (i == 10) chk("af_11", {31'b0, a_af}, 0);
            if (i == 11) chk("af_12", {31'b0, a_af}, 1);
            if (i == 14) chk("full_15", {31'b0, a_full[0]}, 0);
        end
        chk("full_16", {31'b0, a_full[0]}, 1);
        chk("ready_16", {31'b0, a_ready[0]}, 0);
        a_sop[0] = 1'b0; a_eop[0] = 1'b1; a_wd[0] = 32'h110;
        @(negedge clk);
        chk("held_full", {31'b0, a_full[0]}, 1);
        chk("held_head", a_rd[0], 32'h100);
        a_rdy[0] = 1'b1;
        @(negedge clk);
        a_rdy[0] = 1'b0;
        chk("pop_ready", {31'b0, a_ready[0]}, 1);
        chk("pop_full", {31'b0, a_full[0]}, 0);
        chk("pop_head", a_rd[0], 32'h101);
        @(negedge clk);
        a_vld[0] = 1'b0;
        chk("refill_full", {31'b0, a_full[0]}, 1);
        a_rdy[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_vld", {31'b0, a_rvld[0]}, 0);
        chk("drain_af", {31'b0, a_af}, 0);
        a_rdy[0] = 1'b0;

        // framing errors on port 1
        a_vld[1] = 1'b1; a_sop[1] = 1'b0; a_eop[1] = 1'b0; a_wd[1] = 32'hB0;
        @(negedge clk);
        chk("orphan_ferr", {31'b0, a_ferr[1]}, 1);
        chk("orphan_dropped", {31'b0, a_rvld[1]}, 0);
        a_sop[1] = 1'b1; a_wd[1] = 32'hB1;
        @(negedge clk);
        chk("ferr_pulse", {31'b0, a_ferr[1]}, 0);
        a_sop[1] = 1'b0; a_wd[1] = 32'hB2;
        @(negedge clk);
        a_sop[1] = 1'b1; a_wd[1] = 32'hB3;
        @(negedge clk);
        chk("trunc_ferr", {31'b0, a_ferr[1]}, 1);
        a_sop[1] = 1'b0; a_eop[1] = 1'b1; a_wd[1] = 32'hB4;
        @(negedge clk);
        chk("eop_ferr", {31'b0, a_ferr[1]}, 0);
        a_vld[1] = 1'b0; a_eop[1] = 1'b0;
        a_rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("trunc_vld", {31'b0, a_rvld[1]}, 1);
            chk("trunc_data", a_rd[1], 32'hB1 + k);
            chk("trunc_err", {31'b0, a_rerr[1]}, {31'b0, k == 2});
            @(negedge clk);
        end
        chk("trunc_empty", {31'b0, a_rvld[1]}, 0);
        a_rdy[1] = 1'b0;

        // store-and-forward 5-beat packet on port 3
        b_rdy[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_vld[3] = 1'b1; b_sop[3] = (k == 0); b_eop[3] = (k == 4); b_wd[3] = 32'hC0 + k;
            @(negedge clk);
            if (k < 4) chk("sf_hold", {31'b0, b_rvld[3]}, 0);
        end
        b_vld[3] = 1'b0; b_eop[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("sf_vld", {31'b0, b_rvld[3]}, 1);
            chk("sf_data", b_rd[3], 32'hC0 + k);
            @(negedge clk);
        end
        chk("sf_empty", {31'b0, b_rvld[3]}, 0);

        // store-and-forward oversize packet relies on bypass
        b_rdy[0] = 1'b1;
        n = 0;
        j = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            if (b_rvld[0]) begin
                got[n] = b_rd[0];
                if (n == 0) chk("bp_sop", {31'b0, b_rsop[0]}, 1);
                if (n == 19) chk("bp_eop", {31'b0, b_reop[0]}, 1);
                if (n == 0) chk("bp_after_full", j, 16);
                n++;
            end
            if (j < 20) begin
                b_vld[0] = 1'b1; b_sop[0] = (j == 0); b_eop[0] = (j == 19); b_wd[0] = 32'hD00 + j;
                if (b_ready[0]) j++;
            end else begin
                b_vld[0] = 1'b0; b_eop[0] = 1'b0;
            end
            @(negedge clk);
        end
        b_vld[0] = 1'b0;
        chk("bp_count", n, 20);
        for (int k = 0; k < n; k++) chk("bp_data", got[k], 32'hD00 + k);
        @(negedge clk);
        chk("bp_empty", {31'b0, b_rvld[0]}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
